// File: rtl/instr_realigner.sv
// ---------------------------------------------------------------------------
// instr_realigner
//
// Turns the 32-bit, 4-byte-aligned fetch-word stream into one instruction per
// cycle for the compressed-expansion stage. 16-bit compressed instructions are
// split out of the fetch words. 32-bit instructions that straddle two fetch
// words are reassembled from a one-halfword holding register. The output is a
// registered valid/ready slot.
//
// Build option: define RVC_REALIGN_EN to enable compressed splitting and
// straddle reassembly. Without it, every fetch word is passed through as a
// 32-bit instruction, and any encoding that needs realignment is flagged
// illegal.
//
// Ports
//   clk_i                  clock
//   rst_i                  synchronous, active-high reset
//   flush_i                drops the held halfword and the output register
//   fetch_valid_i          fetch word available
//   fetch_data_i[31:0]     fetch word (halfword 0 = bits 15:0)
//   fetch_addr_i[VLEN-1:0] PC of the fetch word (bit 1 = redirect into upper half)
//   fetch_ready_o          fetch word consumed this cycle (combinational)
//   instr_valid_o          output register holds an instruction
//   instr_ready_i          downstream accepts the output instruction
//   instr_o[31:0]          raw instruction (compressed: bits 31:16 are zero)
//   instr_pc_o[VLEN-1:0]   PC of instr_o
//   instr_is_compressed_o  instr_o[1:0] != 2'b11
//   instr_illegal_o        unsupported length encoding
// ---------------------------------------------------------------------------
module instr_realigner #(
    parameter int VLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            fetch_valid_i,
    input  logic [31:0]     fetch_data_i,
    input  logic [VLEN-1:0] fetch_addr_i,
    output logic            fetch_ready_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [VLEN-1:0] instr_pc_o,
    output logic            instr_is_compressed_o,
    output logic            instr_illegal_o
);

    logic            load_ok;
    logic            do_load;
    logic            cand_valid;
    logic [31:0]     cand_instr;
    logic [VLEN-1:0] cand_pc;
    logic            cand_compressed;
    logic            cand_illegal;
    logic            take_word;

    // The output slot can take a new instruction when it is empty or is being
    // drained in this same cycle.
    assign load_ok = !instr_valid_o || instr_ready_i;
    assign do_load = !rst_i && !flush_i && load_ok && cand_valid;

`ifdef RVC_REALIGN_EN

    logic [15:0]     res_q;
    logic [15:0]     res_d;
    logic [VLEN-1:0] res_pc_q;
    logic [VLEN-1:0] res_pc_d;
    logic            res_valid_q;
    logic            res_set;
    logic            res_clr;
    logic            store_only;

    always_comb begin
        cand_valid = 1'b0;
        cand_instr = fetch_data_i;
        cand_pc    = fetch_addr_i;
        take_word  = 1'b0;
        res_set    = 1'b0;
        res_clr    = 1'b0;
        store_only = 1'b0;
        res_d      = fetch_data_i[31:16];
        res_pc_d   = fetch_addr_i + VLEN'(2);

        if (res_valid_q) begin
            if (res_q[1:0] != 2'b11) begin
                // Held compressed instruction: emit it without touching fetch.
                cand_valid = 1'b1;
                cand_instr = {16'h0000, res_q};
                cand_pc    = res_pc_q;
                res_clr    = 1'b1;
            end else if (fetch_valid_i) begin
                // Straddling 32-bit instruction: low half held, high half is
                // the bottom of this word. The top half becomes the new hold.
                cand_valid = 1'b1;
                cand_instr = {fetch_data_i[15:0], res_q};
                cand_pc    = res_pc_q;
                take_word  = 1'b1;
                res_set    = 1'b1;
            end
        end else if (fetch_valid_i) begin
            if (!fetch_addr_i[1]) begin
                take_word  = 1'b1;
                cand_valid = 1'b1;
                if (fetch_data_i[1:0] != 2'b11) begin
                    cand_instr = {16'h0000, fetch_data_i[15:0]};
                    res_set    = 1'b1;
                end
            end else if (fetch_data_i[17:16] != 2'b11) begin
                // Redirect into the upper half, which is a compressed instruction.
                cand_valid = 1'b1;
                cand_instr = {16'h0000, fetch_data_i[31:16]};
                take_word  = 1'b1;
            end else begin
                // Redirect into the start of a straddling 32-bit instruction:
                // park the halfword; the output slot is not needed.
                store_only = 1'b1;
                res_pc_d   = fetch_addr_i;
            end
        end
    end

    assign cand_compressed = (cand_instr[1:0] != 2'b11);
    assign cand_illegal    = !cand_compressed && (cand_instr[4:2] == 3'b111);
    assign fetch_ready_o   = !rst_i && !flush_i && ((take_word && load_ok) || store_only);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_q <= 1'b0;
        end else if (flush_i) begin
            res_valid_q <= 1'b0;
        end else if (store_only || (do_load && res_set)) begin
            res_valid_q <= 1'b1;
        end else if (do_load && res_clr) begin
            res_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && (store_only || (do_load && res_set))) begin
            res_q    <= res_d;
            res_pc_q <= res_pc_d;
        end
    end

`else

    // Pass-through: each fetch word is one 32-bit instruction at its address.
    always_comb begin
        cand_valid = fetch_valid_i;
        cand_instr = fetch_data_i;
        cand_pc    = fetch_addr_i;
        take_word  = fetch_valid_i;
    end

    assign cand_compressed = 1'b0;
    assign cand_illegal    = (fetch_data_i[1:0] != 2'b11) ||
                             (fetch_data_i[4:2] == 3'b111) ||
                             fetch_addr_i[1];
    assign fetch_ready_o   = !rst_i && !flush_i && take_word && load_ok;

`endif

    // Output register stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_valid_o         <= 1'b0;
            instr_o               <= 32'h0;
            instr_pc_o            <= '0;
            instr_is_compressed_o <= 1'b0;
            instr_illegal_o       <= 1'b0;
        end else if (flush_i) begin
            instr_valid_o <= 1'b0;
        end else if (load_ok) begin
            instr_valid_o <= cand_valid;
            if (cand_valid) begin
                instr_o               <= cand_instr;
                instr_pc_o            <= cand_pc;
                instr_is_compressed_o <= cand_compressed;
                instr_illegal_o       <= cand_illegal;
            end
        end
    end

endmodule

// File: tb/tb_instr_realigner.sv
module tb_instr_realigner;

    localparam int VLEN = 64;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            fetch_valid_i;
    logic [31:0]     fetch_data_i;
    logic [VLEN-1:0] fetch_addr_i;
    logic            fetch_ready_o;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [31:0]     instr_o;
    logic [VLEN-1:0] instr_pc_o;
    logic            instr_is_compressed_o;
    logic            instr_illegal_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    instr_realigner #(.VLEN(VLEN)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .flush_i               (flush_i),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_data_i          (fetch_data_i),
        .fetch_addr_i          (fetch_addr_i),
        .fetch_ready_o         (fetch_ready_o),
        .instr_valid_o         (instr_valid_o),
        .instr_ready_i         (instr_ready_i),
        .instr_o               (instr_o),
        .instr_pc_o            (instr_pc_o),
        .instr_is_compressed_o (instr_is_compressed_o),
        .instr_illegal_o       (instr_illegal_o)
    );

    typedef struct {
        logic            rst;
        logic            flush;
        logic            fv;
        logic [31:0]     data;
        logic [VLEN-1:0] addr;
        logic            rdy;
        logic            e_fr;
        logic            e_v;
        logic            chkd;
        logic [31:0]     e_instr;
        logic [VLEN-1:0] e_pc;
        logic            e_c;
        logic            e_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic flush, input logic fv,
                                input logic [31:0] data, input logic [VLEN-1:0] addr,
                                input logic rdy, input logic e_fr, input logic e_v,
                                input logic chkd, input logic [31:0] e_instr,
                                input logic [VLEN-1:0] e_pc, input logic e_c,
                                input logic e_ill);
        vec_t v;
        v.rst = rst; v.flush = flush; v.fv = fv; v.data = data; v.addr = addr;
        v.rdy = rdy; v.e_fr = e_fr; v.e_v = e_v; v.chkd = chkd;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_c = e_c; v.e_ill = e_ill;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    // Drive one cycle: inputs set at the falling edge, fetch_ready_o checked
    // mid-cycle, registered outputs checked just after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk_i);
        rst_i         = v.rst;
        flush_i       = v.flush;
        fetch_valid_i = v.fv;
        fetch_data_i  = v.data;
        fetch_addr_i  = v.addr;
        instr_ready_i = v.rdy;
        #1;
        chk("fetch_ready", idx, 64'(fetch_ready_o), 64'(v.e_fr));
        @(posedge clk_i);
        #1;
        chk("instr_valid", idx, 64'(instr_valid_o), 64'(v.e_v));
        if (v.chkd) begin
            chk("instr", idx, 64'(instr_o), 64'(v.e_instr));
            chk("instr_pc", idx, 64'(instr_pc_o), 64'(v.e_pc));
            chk("compressed", idx, 64'(instr_is_compressed_o), 64'(v.e_c));
            chk("illegal", idx, 64'(instr_illegal_o), 64'(v.e_ill));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog step=0 actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0;
        fetch_data_i = 32'h0; fetch_addr_i = '0; instr_ready_i = 1'b1;

`ifdef RVC_REALIGN_EN
        vecs.push_back(mk(1,0,0,32'h0,64'h0,1, 0,0,1,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,1,32'h00000013,64'h1000,1, 1,1,1,32'h00000013,64'h1000,0,0));
        vecs.push_back(mk(0,0,1,32'h45014501,64'h2000,1, 1,1,1,32'h00004501,64'h2000,1,0));
        vecs.push_back(mk(0,0,0,32'h0,64'h0,1, 0,1,1,32'h00004501,64'h2002,1,0));
        vecs.push_back(mk(0,0,1,32'h00134501,64'h3000,1, 1,1,1,32'h00004501,64'h3000,1,0));
        vecs.push_back(mk(0,0,1,32'h45010000,64'h3004,1, 1,1,1,32'h00000013,64'h3002,0,0));
        vecs.push_back(mk(0,0,0,32'h0,64'h0,1, 0,1,1,32'h00004501,64'h3006,1,0));
        vecs.push_back(mk(0,0,1,32'h0013ABCD,64'h4002,1, 1,0,0,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,1,32'h12340000,64'h4004,1, 1,1,1,32'h00000013,64'h4002,0,0));
        vecs.push_back(mk(0,1,1,32'h00000013,64'h4008,1, 0,0,0,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,0,32'h0,64'h0,1, 0,0,0,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,1,32'h0000007F,64'h4800,1, 1,1,1,32'h0000007F,64'h4800,0,1));
        vecs.push_back(mk(0,0,1,32'h45014501,64'h5000,1, 1,1,1,32'h00004501,64'h5000,1,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,1,32'h00000013,64'h5004,0, 0,1,1,32'h00004501,64'h5000,1,0));
        vecs.push_back(mk(0,1,0,32'h0,64'h0,0, 0,0,0,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,1,32'h00000013,64'h5000,1, 1,1,1,32'h00000013,64'h5000,0,0));
        vecs.push_back(mk(0,0,0,32'h0,64'h0,1, 0,0,0,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,1,32'h00134501,64'h6000,1, 1,1,1,32'h00004501,64'h6000,1,0));
        vecs.push_back(mk(1,0,0,32'h0,64'h0,1, 0,0,1,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,0,32'h0,64'h0,1, 0,0,1,32'h0,64'h0,0,0));
`else
        vecs.push_back(mk(1,0,0,32'h0,64'h0,1, 0,0,1,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,1,32'h00000013,64'h1000,1, 1,1,1,32'h00000013,64'h1000,0,0));
        vecs.push_back(mk(0,0,1,32'h0000007F,64'h1004,1, 1,1,1,32'h0000007F,64'h1004,0,1));
        vecs.push_back(mk(0,0,1,32'h45014501,64'h1008,1, 1,1,1,32'h45014501,64'h1008,0,1));
        vecs.push_back(mk(0,0,1,32'h00000013,64'h100A,1, 1,1,1,32'h00000013,64'h100A,0,1));
        vecs.push_back(mk(0,0,0,32'h0,64'h0,1, 0,0,0,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,1,32'h00A00093,64'h2000,1, 1,1,1,32'h00A00093,64'h2000,0,0));
        vecs.push_back(mk(0,0,1,32'h00012347,64'h2004,0, 0,1,1,32'h00A00093,64'h2000,0,0));
        vecs.push_back(mk(0,0,1,32'h00012347,64'h2004,0, 0,1,1,32'h00A00093,64'h2000,0,0));
        vecs.push_back(mk(0,0,1,32'h00012347,64'h2004,1, 1,1,1,32'h00012347,64'h2004,0,0));
        vecs.push_back(mk(0,1,1,32'h00000013,64'h3000,1, 0,0,0,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,1,32'h00000013,64'h3000,1, 1,1,1,32'h00000013,64'h3000,0,0));
        vecs.push_back(mk(1,0,1,32'h00000013,64'h3004,1, 0,0,1,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,0,32'h0,64'h0,1, 0,0,1,32'h0,64'h0,0,0));
        vecs.push_back(mk(0,0,1,32'h00000013,64'hFFFFFFFFFFFFFFFC,1,
                          1,1,1,32'h00000013,64'hFFFFFFFFFFFFFFFC,0,0));
`endif

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

`ifdef RVC_REALIGN_EN
        // Straddle waiting on a late fetch word: holds with no output.
        apply(mk(0,0,1,32'h00134501,64'h9000,1, 1,1,1,32'h00004501,64'h9000,1,0), 100);
        apply(mk(0,0,0,32'h0,64'h0,1, 0,0,0,32'h0,64'h0,0,0), 101);
        apply(mk(0,0,0,32'h0,64'h0,1, 0,0,0,32'h0,64'h0,0,0), 102);
        apply(mk(0,0,1,32'h45010000,64'h9004,1, 1,1,1,32'h00000013,64'h9002,0,0), 103);
        apply(mk(0,0,0,32'h0,64'h0,1, 0,1,1,32'h00004501,64'h9006,1,0), 104);
        // Redirect into a compressed upper half.
        apply(mk(0,0,1,32'h4501ABCD,64'hA002,1, 1,1,1,32'h00004501,64'hA002,1,0), 105);
        apply(mk(0,0,0,32'h0,64'h0,1, 0,0,0,32'h0,64'h0,0,0), 106);
`else
        // Back-to-back fetch words, one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            logic [VLEN-1:0] a;
            w = 32'h00000013 | (32'(i) << 7);
            a = 64'h8000 + 64'(4 * i);
            apply(mk(0,0,1,w,a,1, 1,1,1,w,a,0,0), 100 + i);
        end
        apply(mk(0,0,0,32'h0,64'h0,1, 0,0,0,32'h0,64'h0,0,0), 104);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
